exec_stage: RTL

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_pkg.sv | 27 ++
 rtl/sync_counter.sv | 23 ++
 rtl/exec_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Instruction encoding shared by fetch, the execute stage and the core wrapper.
// 16-bit word: opcode in [15:12], immediate in [11:0].
package exec_pkg;

  localparam int unsigned InsW    = 16;
  localparam int unsigned OpW     = 4;
  localparam int unsigned ImmW    = 12;
  localparam int unsigned SyncIdW = 8;

  localparam logic [OpW-1:0] OpNop   = 4'h0;
  localparam logic [OpW-1:0] OpAdd   = 4'h1;
  localparam logic [OpW-1:0] OpSub   = 4'h2;
  localparam logic [OpW-1:0] OpPinc  = 4'h3;
  localparam logic [OpW-1:0] OpPdec  = 4'h4;
  localparam logic [OpW-1:0] OpBrz   = 4'h5;
  localparam logic [OpW-1:0] OpBr    = 4'h6;
  localparam logic [OpW-1:0] OpBrnz  = 4'h7;
  localparam logic [OpW-1:0] OpSync  = 4'h8;
  localparam logic [OpW-1:0] OpPrint = 4'h9;

  // SYNC reuses imm: [11:8] = expected core count, [7:0] = barrier id.
  typedef struct packed {
    logic [OpW-1:0]  op;
    logic [ImmW-1:0] imm;
  } ins_t;

endpackage

// File: rtl/sync_counter.sv
// Counts the cores whose current instruction is a SYNC on the given barrier id.
module sync_counter
  import exec_pkg::*;
#(
  parameter int unsigned NCORES = 4
) (
  input  logic [NCORES*InsW-1:0]      all_ins,
  input  logic [SyncIdW-1:0]          sync_id,
  output logic [$clog2(NCORES+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(NCORES + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (all_ins[InsW*i+ImmW +: OpW] == OpSync && all_ins[InsW*i +: SyncIdW] == sync_id) begin
        count = count + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage of a tape-machine core: arithmetic on the current cell, pointer
// moves, branches, cross-core SYNC barriers and a PRINT handshake.
module exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned NCORES    = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RESET_PTR = 128,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   ins_in,
  input  logic [DATA_W-1:0]             val_in,
  input  logic                          fork_valid,
  input  logic [ADDR_W-1:0]             fork_ptr,
  input  logic [NCORES*16-1:0]          all_ins,
  input  logic                          print_ready,
  output logic [DATA_W-1:0]             val_out,
  output logic                          wb_en,
  output logic [ADDR_W-1:0]             ptr_select,
  output logic [ADDR_W-1:0]             ptr_wb,
  output logic [15:0]                   branch_val,
  output logic                          branch_en,
  output logic [15:0]                   current_ins,
  output logic                          stall,
  output logic [$clog2(NCORES+1)-1:0]   num_syncs,
  output logic [DATA_W-1:0]             print_data,
  output logic                          print_valid,
  output logic                          next_print_valid,
  output logic [15:0]                   stall_cnt
);

  localparam bit Sat = (SATURATE != 0);

  logic [15:0]        ins_q;
  logic [DATA_W-1:0]  val_q;
  logic [ADDR_W-1:0]  ptr_q;
  logic [15:0]        stall_cnt_q;

  ins_t               ins;
  ins_t               ins_next;
  logic [ImmW-1:0]    step;
  logic [DATA_W-1:0]  k_val;
  logic [ADDR_W-1:0]  k_ptr;
  logic [DATA_W:0]    add_res;
  logic [DATA_W:0]    sub_res;
  logic [ADDR_W-1:0]  ptr_next;
  logic               sync_wait;

  assign ins      = ins_t'(ins_q);
  assign ins_next = ins_t'(ins_in);

  // An immediate of zero means a step of one.
  assign step  = (ins.imm == '0) ? ImmW'(1) : ins.imm;
  assign k_val = DATA_W'(step);
  assign k_ptr = ADDR_W'(step);

  // Extra top bit carries out of ADD and borrows out of SUB.
  assign add_res = {1'b0, val_q} + {1'b0, k_val};
  assign sub_res = {1'b0, val_q} - {1'b0, k_val};

  sync_counter #(
    .NCORES (NCORES)
  ) u_sync_counter (
    .all_ins (all_ins),
    .sync_id (ins.imm[SyncIdW-1:0]),
    .count   (num_syncs)
  );

  assign sync_wait = (32'(num_syncs) != 32'(ins.imm[11:8]));

  always_comb begin
    val_out     = '0;
    wb_en       = 1'b0;
    ptr_next    = ptr_q;
    branch_val  = '0;
    branch_en   = 1'b0;
    stall       = 1'b0;
    print_data  = '0;
    print_valid = 1'b0;
    case (ins.op)
      OpAdd: begin
        wb_en   = 1'b1;
        val_out = (Sat && add_res[DATA_W]) ? '1 : add_res[DATA_W-1:0];
      end
      OpSub: begin
        wb_en   = 1'b1;
        val_out = (Sat && sub_res[DATA_W]) ? '0 : sub_res[DATA_W-1:0];
      end
      OpPinc: ptr_next = ptr_q + k_ptr;
      OpPdec: ptr_next = ptr_q - k_ptr;
      OpBrz: begin
        branch_val = {4'h0, ins.imm};
        branch_en  = (val_q == '0);
      end
      OpBr: begin
        branch_val = {4'h0, ins.imm};
        branch_en  = 1'b1;
      end
      OpBrnz: begin
        branch_val = {4'h0, ins.imm};
        branch_en  = (val_q != '0);
      end
      OpSync: stall = sync_wait;
      OpPrint: begin
        print_valid = 1'b1;
        print_data  = val_q;
        stall       = ~print_ready;
      end
      default: ;
    endcase
  end

  // A fork restart beats any pointer move decoded this cycle.
  assign ptr_select = fork_valid ? fork_ptr : ptr_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ins_q       <= '0;
      val_q       <= '0;
      ptr_q       <= ADDR_W'(RESET_PTR);
      stall_cnt_q <= '0;
    end else begin
      val_q <= val_in;
      ptr_q <= ptr_select;
      if (!stall) begin
        ins_q <= ins_in;
      end
      if (stall && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign current_ins      = ins_q;
  assign ptr_wb           = ptr_q;
  assign stall_cnt        = stall_cnt_q;
  assign next_print_valid = (ins_next.op == OpPrint);

endmodule
